// File: rtl/can_rx_frame_fifo.sv
// Acceptance-filtered show-ahead frame FIFO between can_rx and the host.
// Optional per-entry timestamp: define CAN_RX_FIFO_TIMESTAMP_EN.
module can_rx_frame_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_valid_i,
  input  logic [28:0]       frame_id_i,
  input  logic              frame_rtr_i,
  input  logic [3:0]        frame_dlc_i,
  input  logic [63:0]       frame_data_i,
  input  logic              frame_crc_ok_i,
  input  logic [28:0]       cfg_code_i,
  input  logic [28:0]       cfg_mask_i,
  input  logic              clear_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [28:0]       rd_id_o,
  output logic              rd_rtr_o,
  output logic [3:0]        rd_dlc_o,
  output logic [63:0]       rd_data_o,
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
  output logic [15:0]       rd_timestamp_o,
`endif
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic [7:0]        drop_count_o
);

  localparam int BASE_W = 98;
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
  localparam int ENTRY_W = BASE_W + 16;
`else
  localparam int ENTRY_W = BASE_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;

  logic               id_match;
  logic               accept;
  logic               full;
  logic               pop;
  logic               push;
  logic               lost;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

`ifdef CAN_RX_FIFO_TIMESTAMP_EN
  logic [15:0]        ts_q, ts_d;

  always_comb begin
    ts_d = ts_q + 16'd1;
    if (clear_i) ts_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  assign wr_entry = {ts_q, frame_id_i, frame_rtr_i, frame_dlc_i, frame_data_i};
`else
  assign wr_entry = {frame_id_i, frame_rtr_i, frame_dlc_i, frame_data_i};
`endif

  assign id_match = (((frame_id_i ^ cfg_code_i) & cfg_mask_i) == 29'd0);
  assign accept   = frame_valid_i & frame_crc_ok_i & id_match;
  assign full     = (count_q == DEPTH_C);
  assign rd_valid_o = (count_q != '0);
  // clear_i swallows any push or pop issued in the same cycle.
  assign pop      = rd_valid_o & rd_ready_i & ~clear_i;
  assign push     = accept & (~full | pop) & ~clear_i;
  assign lost     = accept & ~push & ~clear_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
      if (lost) begin
        overflow_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; empty-state outputs are masked instead.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = rd_valid_o ? mem_q[rd_ptr_q] : '0;

  assign rd_data_o = head[63:0];
  assign rd_dlc_o  = head[67:64];
  assign rd_rtr_o  = head[68];
  assign rd_id_o   = head[97:69];
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
  assign rd_timestamp_o = head[113:98];
`endif

  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Directed scoreboard bench for can_rx_frame_fifo (DEPTH=8).
module tb_can_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic [28:0] frame_id;
  logic        frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic        frame_crc_ok;
  logic [28:0] cfg_code;
  logic [28:0] cfg_mask;
  logic        clear;
  logic        rd_valid;
  logic        rd_ready;
  logic [28:0] rd_id;
  logic        rd_rtr;
  logic [3:0]  rd_dlc;
  logic [63:0] rd_data;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
  logic [15:0] rd_timestamp;
`endif

  always #5 clk = ~clk;

  can_rx_frame_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .frame_valid_i(frame_valid), .frame_id_i(frame_id), .frame_rtr_i(frame_rtr),
    .frame_dlc_i(frame_dlc), .frame_data_i(frame_data), .frame_crc_ok_i(frame_crc_ok),
    .cfg_code_i(cfg_code), .cfg_mask_i(cfg_mask), .clear_i(clear),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_id_o(rd_id), .rd_rtr_o(rd_rtr), .rd_dlc_o(rd_dlc), .rd_data_o(rd_data),
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
    .rd_timestamp_o(rd_timestamp),
`endif
    .count_o(count), .overflow_o(overflow), .drop_count_o(drop_count)
  );

  int passed = 0;
  int total  = 0;

  logic [28:0] sb_q[$];
  int          m_drop = 0;
  bit          m_ovf  = 1'b0;

  function automatic logic [63:0] mk_data(input logic [28:0] id);
    return {3'b000, id, 3'b101, ~id};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(sb_q.size()));
    chk({tag, "_valid"}, 64'(rd_valid), 64'(sb_q.size() != 0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, "_drop"}, 64'(drop_count), 64'(m_drop));
    if (sb_q.size() == 0) begin
      chk({tag, "_empty_id"}, 64'(rd_id), 64'd0);
      chk({tag, "_empty_data"}, rd_data, 64'd0);
    end else begin
      chk({tag, "_head_id"}, 64'(rd_id), 64'(sb_q[0]));
    end
  endtask

  // One clock: drive inputs, update the model, compare the head on pop.
  task automatic cycle(input bit fv, input logic [28:0] id, input bit crc,
                       input bit rdy, input bit clr);
    bit m_pop, m_acc;
    logic [28:0] exp_id;
    frame_valid  = fv;
    frame_id     = id;
    frame_rtr    = id[4];
    frame_dlc    = id[3:0];
    frame_data   = mk_data(id);
    frame_crc_ok = crc;
    rd_ready     = rdy;
    clear        = clr;
    m_pop = (sb_q.size() != 0) && rdy;
    m_acc = fv && crc && (((id ^ cfg_code) & cfg_mask) == 29'd0);
    if (clr) begin
      sb_q.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (m_pop) begin
        exp_id = sb_q.pop_front();
        chk("pop_id", 64'(rd_id), 64'(exp_id));
        chk("pop_data", rd_data, mk_data(exp_id));
        chk("pop_dlc_rtr", 64'({rd_rtr, rd_dlc}), 64'({exp_id[4], exp_id[3:0]}));
      end
      if (m_acc) begin
        if (sb_q.size() < 8 || m_pop) sb_q.push_back(id);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    rd_ready    = 1'b0;
    clear       = 1'b0;
  endtask

  initial begin
`ifdef CAN_RX_FIFO_TIMESTAMP_EN
    logic [15:0] ts0;
`endif
    rst = 1'b1; frame_valid = 1'b0; frame_id = '0; frame_rtr = 1'b0; frame_dlc = '0;
    frame_data = '0; frame_crc_ok = 1'b0; cfg_code = '0; cfg_mask = '0;
    clear = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset");

    // single frame through, then pop
    cycle(1'b1, 29'h0A5_1234, 1'b1, 1'b0, 1'b0);
    check_state("t1_push");
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_state("t1_pop");
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_state("t1_ready_no_data");

    // acceptance filter and CRC rejects
    cfg_code = 29'h1000_0000;
    cfg_mask = 29'h1FF0_0000;
    cycle(1'b1, 29'h1000_0ABC, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 29'h0800_0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 29'h1000_0DEF, 1'b0, 1'b0, 1'b0);
    check_state("t2_filter");
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cfg_code = '0;
    cfg_mask = '0;

    // overflow: DEPTH+3 frames with no pop
    for (int i = 0; i < 11; i++) cycle(1'b1, 29'(32'h100 + i), 1'b1, 1'b0, 1'b0);
    check_state("t3_full");
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_state("t3_drained");

    // full FIFO with simultaneous push and pop
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 29'(32'h200 + i), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 29'h0000_0555, 1'b1, 1'b1, 1'b0);
    check_state("t4_full_pushpop");
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_state("t4_drained");

    // drop counter saturation, then pointer wrap under push/pop pairs
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 29'(32'h300 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 29'(32'h1000 + i), 1'b1, 1'b0, 1'b0);
    check_state("t5_saturated");
    for (int i = 0; i < 20; i++) cycle(1'b1, 29'(32'h2000 + i * 7), 1'b1, 1'b1, 1'b0);
    check_state("t5_wrap");
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_state("t5_drained");

    // clear with a frame and a pop request in the same cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, 29'(32'h400 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 29'(32'h500 + i), 1'b1, 1'b0, 1'b0);
    check_state("t6_before_clear");
    cycle(1'b1, 29'h0000_0777, 1'b1, 1'b1, 1'b1);
    check_state("t6_clear");

`ifdef CAN_RX_FIFO_TIMESTAMP_EN
    cycle(1'b1, 29'h0000_0601, 1'b1, 1'b0, 1'b0);
    repeat (9) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 29'h0000_0602, 1'b1, 1'b0, 1'b0);
    ts0 = rd_timestamp;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("ts_delta", 64'(16'(rd_timestamp - ts0)), 64'd10);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("ts_empty", 64'(rd_timestamp), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
